// File: rtl/ram_ctrl_pkg.sv
// Shared types and widths for the output-values RAM controller.
package ram_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef logic [0:0] port_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a burst limit.
// The last owner may keep the port for at most BURST_MAX grants while the other requester waits.
module rr_arbiter2
  import ram_ctrl_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_id_t   owner
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  logic [3:0] burst_cnt;
  logic       keep_burst;
  port_id_t   winner;

  // A burst only continues if the previous cycle was granted (burst_cnt != 0).
  always_comb begin
    keep_burst = (burst_cnt != 4'd0) && (burst_cnt < BURST_LIM);
    winner     = owner;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = keep_burst ? owner : ~owner;
      default: winner = owner;
    endcase
    gnt = 2'b00;
    if (rst_n && (req != 2'b00)) begin
      gnt[0] = (winner == 1'b0);
      gnt[1] = (winner == 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= 1'b1;
      burst_cnt <= 4'd0;
    end else if (gnt != 2'b00) begin
      if (winner == owner) begin
        burst_cnt <= (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd1;
      end
      owner <= winner;
    end else begin
      burst_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/output_ram_arbiter.sv
// Round-robin sequencer sharing the single-port 16x8 output RAM between the
// result writer (0) and the output reader (1); returns read data one cycle later.
module output_ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  logic [1:0]        gnt;
  logic              any_gnt;
  port_id_t          owner;
  ram_req_t          req_sel;
  logic [ADDR_W-1:0] held_addr;
  logic [DATA_W-1:0] held_data;
  logic              rd_pend;

  rr_arbiter2 #(.BURST_MAX(BURST_MAX)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .gnt   (gnt),
    .owner (owner)
  );

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign any_gnt = gnt[0] | gnt[1];

  always_comb begin
    if (gnt[1]) begin
      req_sel.we    = we1;
      req_sel.addr  = addr1;
      req_sel.wdata = wdata1;
    end else begin
      req_sel.we    = we0;
      req_sel.addr  = addr0;
      req_sel.wdata = wdata0;
    end
  end

  // Idle cycles replay the last granted address so ram_q stays stable.
  assign ram_we   = any_gnt & req_sel.we;
  assign ram_addr = any_gnt ? req_sel.addr  : held_addr;
  assign ram_data = any_gnt ? req_sel.wdata : held_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_addr <= '0;
      held_data <= '0;
      rd_pend   <= 1'b0;
    end else begin
      rd_pend <= any_gnt & ~req_sel.we;
      if (any_gnt) begin
        held_addr <= req_sel.addr;
        held_data <= req_sel.wdata;
      end
    end
  end

  // owner was updated on the same edge that launched the read, so it names the reader.
  assign rvalid0 = rd_pend & (owner == 1'b0);
  assign rvalid1 = rd_pend & (owner == 1'b1);
  assign rdata   = ram_q;

endmodule

// File: tb/tb_output_ram_arbiter.sv
// Bench for output_ram_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a rule-level model of arbitration and RAM contents.
module tb_output_ram_arbiter;

  localparam int BM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [7:0] rdata, ram_data, ram_q;
  logic [3:0] ram_addr;

  always #5 clk = ~clk;

  output_ram_arbiter #(.BURST_MAX(BM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  // RAM with registered read address
  logic [7:0] mem [16];
  logic [3:0] q_addr = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    q_addr <= ram_addr;
  end
  assign ram_q = mem[q_addr];

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  int         m_owner = 1;
  int         m_burst = 0;
  logic [3:0] m_held_addr = '0;
  logic [7:0] m_held_data = '0;
  bit         m_pend = 0;
  int         m_pend_req = 0;
  logic [7:0] m_pend_data = '0;
  logic [7:0] mem_ref [16];
  logic [1:0] gnt_last = '0;

  always @(negedge clk) begin : model_chk
    int         w;
    bit         g, e_we;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    if (!rst_n) begin
      check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);
      check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      check("rst_addr", 32'(ram_addr), 32'd0);
      m_owner = 1; m_burst = 0; m_held_addr = '0; m_held_data = '0;
      m_pend = 0; gnt_last = '0;
    end else begin
      g = req0 | req1;
      if (req0 && !req1)                  w = 0;
      else if (req1 && !req0)             w = 1;
      else if (m_burst > 0 && m_burst < BM) w = m_owner;
      else                                w = 1 - m_owner;
      e_addr = g ? (w == 1 ? addr1 : addr0) : m_held_addr;
      e_data = g ? (w == 1 ? wdata1 : wdata0) : m_held_data;
      e_we   = g && (w == 1 ? we1 : we0);
      check("gnt0", 32'(gnt0), 32'(g && w == 0));
      check("gnt1", 32'(gnt1), 32'(g && w == 1));
      check("ram_we", 32'(ram_we), 32'(e_we));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      check("ram_data", 32'(ram_data), 32'(e_data));
      check("rvalid0", 32'(rvalid0), 32'(m_pend && m_pend_req == 0));
      check("rvalid1", 32'(rvalid1), 32'(m_pend && m_pend_req == 1));
      if (m_pend) check("rdata", 32'(rdata), 32'(m_pend_data));
      if (g) begin
        if (w == m_owner) m_burst = (m_burst >= 15) ? 15 : m_burst + 1;
        else              m_burst = 1;
        m_owner = w;
        m_held_addr = e_addr;
        m_held_data = e_data;
        if (e_we) mem_ref[e_addr] = e_data;
        m_pend = !e_we;
        m_pend_req = w;
        m_pend_data = mem_ref[e_addr];
      end else begin
        m_burst = 0;
        m_pend = 0;
      end
      gnt_last = {gnt1, gnt0};
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0;
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  initial begin
    logic [11:0] pat;
    int          cnt;
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      mem_ref[i] = '0;
    end
    cyc(); cyc(); cyc();
    rst_n = 1;
    cyc();

    // 1: write then read addr 3
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'hA5;
    #3;
    check("t1_gnt0", 32'(gnt0), 32'd1);
    check("t1_we", 32'(ram_we), 32'd1);
    check("t1_addr", 32'(ram_addr), 32'd3);
    cyc();
    we0 = 0;
    #3 check("t1_rd_gnt0", 32'(gnt0), 32'd1);
    cyc();
    req0 = 0;
    #3;
    check("t1_rvalid0", 32'(rvalid0), 32'd1);
    check("t1_rdata", 32'(rdata), 32'hA5);

    // 2: tied requests, burst limit 4
    cyc();
    do_reset();
    cyc();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 4'd1; addr1 = 4'd2;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      #3 pat = {pat[10:0], gnt1};
      cyc();
    end
    check("t2_pattern", 32'(pat), 32'(12'b000011110000));
    req0 = 0; req1 = 0;
    #3 check("t2_last_rvalid0", 32'(rvalid0), 32'd1);

    // 3: requester 1 alone is never throttled
    cyc();
    req1 = 1; we1 = 0; addr1 = 4'd9;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #3 if (gnt1) cnt++;
      cyc();
    end
    check("t3_gnt1_count", 32'(cnt), 32'd10);

    // 4: write by 1, read by 0 of addr 15 next cycle
    req1 = 1; we1 = 1; addr1 = 4'd15; wdata1 = 8'h3C;
    cyc();
    req1 = 0; req0 = 1; we0 = 0; addr0 = 4'd15;
    #3 check("t4_gnt0", 32'(gnt0), 32'd1);
    cyc();
    req0 = 0;
    #3;
    check("t4_rvalid0", 32'(rvalid0), 32'd1);
    check("t4_rdata", 32'(rdata), 32'h3C);

    // 5: reset drops a pending read response
    cyc();
    req0 = 1; we0 = 0; addr0 = 4'd2;
    #3 check("t5_gnt0", 32'(gnt0), 32'd1);
    #4 rst_n = 0; req0 = 0;
    #4 check("t5_rvalid_in_rst", 32'({rvalid1, rvalid0}), 32'd0);
    cyc(); cyc();
    rst_n = 1;
    #3 check("t5_rvalid_after", 32'({rvalid1, rvalid0}), 32'd0);
    cyc();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 4'd4; addr1 = 4'd5;
    #3 check("t5_first_tie", 32'({gnt1, gnt0}), 32'd1);
    cyc();
    req0 = 0; req1 = 0;

    // 6: idle after read of addr 7
    cyc();
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 8'h5A;
    cyc();
    we0 = 0;
    cyc();
    req0 = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #3;
      check("t6_we", 32'(ram_we), 32'd0);
      check("t6_addr", 32'(ram_addr), 32'd7);
      check("t6_rdata", 32'(rdata), 32'h5A);
      check("t6_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    end

    // Random traffic; a request is held until granted
    for (int i = 0; i < 600; i++) begin
      cyc();
      if (i == 300) begin
        rst_n = 0;
        #6 rst_n = 1;
        continue;
      end
      if (!req0 || gnt_last[0]) begin
        req0 = ($urandom_range(0, 99) < 65);
        we0 = $urandom_range(0, 1) == 1;
        addr0 = 4'($urandom_range(0, 15));
        wdata0 = 8'($urandom_range(0, 255));
      end
      if (!req1 || gnt_last[1]) begin
        req1 = ($urandom_range(0, 99) < 65);
        we1 = $urandom_range(0, 2) == 0;
        addr1 = 4'($urandom_range(0, 15));
        wdata1 = 8'($urandom_range(0, 255));
      end
    end
    req0 = 0; req1 = 0;
    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
